// File: rtl/dram_loader.sv
// Streams one image of pixel bytes into data RAM, then checks a trailing
// modulo-256 checksum byte and starts the downsampling processor on a match.
module dram_loader #(
  parameter int ADDR_W    = 19,
  parameter int IMG_BYTES = 65536,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              power_ON,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              dRamWrEn,
  output logic [ADDR_W-1:0] dRamWrAddr,
  output logic [7:0]        dRamWrData,
  output logic              load_done,
  output logic              load_err,
  output logic              proc_start
);

  // state | meaning
  // IDLE  | waiting for the first load_req after reset
  // LOAD  | accepting pixel bytes and writing them to RAM
  // CHECK | accepting the checksum byte (not written)
  // DONE  | checksum matched; load_done held, proc_start pulsed on entry
  // ERR   | checksum mismatch; load_err held
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(IMG_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic [7:0]        csum;
  logic              xfer;

  // in_ready decodes only the state register, so it never depends on in_valid
  assign in_ready = (state == LOAD) || (state == CHECK);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!power_ON) begin
      state      <= IDLE;
      count      <= '0;
      csum       <= '0;
      dRamWrEn   <= 1'b0;
      dRamWrAddr <= '0;
      dRamWrData <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      proc_start <= 1'b0;
    end else begin
      dRamWrEn   <= 1'b0;
      proc_start <= 1'b0;
      case (state)
        IDLE: begin
          if (load_req) begin
            count <= '0;
            csum  <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            dRamWrEn   <= 1'b1;
            dRamWrAddr <= BASE_A + count;
            dRamWrData <= in_data;
            csum       <= csum + in_data;
            if (count == LAST) state <= CHECK;
            else               count <= count + ADDR_W'(1);
          end
        end
        CHECK: begin
          if (xfer) begin
            if (in_data == csum) begin
              state      <= DONE;
              load_done  <= 1'b1;
              proc_start <= 1'b1;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          if (load_req) begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            count     <= '0;
            csum      <= '0;
            state     <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_loader.sv
// Directed bench for dram_loader: a per-cycle vector table for a clean load,
// then hand-written sequences for errors, stalls, reset abort, reload and wrap.
module tb_dram_loader;

  logic        clk = 1'b0;
  logic        power_ON, load_req, in_valid;
  logic [7:0]  in_data;

  logic        in_ready, dRamWrEn, load_done, load_err, proc_start;
  logic [18:0] dRamWrAddr;
  logic [7:0]  dRamWrData;

  logic        w_ready, w_we, w_done, w_err, w_ps;
  logic [18:0] w_addr;
  logic [7:0]  w_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dram_loader #(.ADDR_W(19), .IMG_BYTES(4), .BASE_ADDR(140)) u_dut (
    .clk(clk), .power_ON(power_ON), .load_req(load_req), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .dRamWrEn(dRamWrEn),
    .dRamWrAddr(dRamWrAddr), .dRamWrData(dRamWrData), .load_done(load_done),
    .load_err(load_err), .proc_start(proc_start)
  );

  dram_loader #(.ADDR_W(19), .IMG_BYTES(4), .BASE_ADDR(524286)) u_wrap (
    .clk(clk), .power_ON(power_ON), .load_req(load_req), .in_valid(in_valid),
    .in_data(in_data), .in_ready(w_ready), .dRamWrEn(w_we),
    .dRamWrAddr(w_addr), .dRamWrData(w_data), .load_done(w_done),
    .load_err(w_err), .proc_start(w_ps)
  );

  // write and pulse logs, sampled mid-cycle
  logic [18:0] wa [64];
  logic [7:0]  wd [64];
  logic [18:0] xa [64];
  logic [7:0]  xd [64];
  int wn = 0, xn = 0, psn = 0;

  always @(negedge clk) begin
    if (dRamWrEn && wn < 64) begin
      wa[wn] <= dRamWrAddr;
      wd[wn] <= dRamWrData;
      wn     <= wn + 1;
    end
    if (w_we && xn < 64) begin
      xa[xn] <= w_addr;
      xd[xn] <= w_data;
      xn     <= xn + 1;
    end
    if (proc_start) psn <= psn + 1;
  end

  typedef struct {
    logic        req;
    logic        vld;
    logic [7:0]  din;
    logic        rdy;
    logic        we;
    logic [18:0] addr;
    logic [7:0]  dat;
    logic        done;
    logic        err;
    logic        ps;
  } vec_t;

  vec_t vt [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    if (gap) step();
  endtask

  task automatic send_img(input logic [7:0] p0, p1, p2, p3, ck, input bit gap);
    send_byte(p0, gap);
    send_byte(p1, gap);
    send_byte(p2, gap);
    send_byte(p3, gap);
    send_byte(ck, gap);
  endtask

  task automatic chk_img(input string nm, input int s, input logic [7:0] p0, p1, p2, p3);
    logic [7:0] p [4];
    p = '{p0, p1, p2, p3};
    chk({nm, "_nwr"}, 64'(wn - s), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_addr"}, 64'(wa[s+i]), 64'(140 + i));
      chk({nm, "_data"}, 64'(wd[s+i]), 64'(p[i]));
    end
  endtask

  function automatic logic [32:0] outs();
    return {in_ready, dRamWrEn, dRamWrAddr, dRamWrData, load_done, load_err, proc_start};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2, x0, p0;
    logic [32:0] e;

    //             req vld din   rdy we addr  dat done err ps
    vt[0] = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 19'd0,   8'd0,  1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 8'd10,  1'b1, 1'b1, 19'd140, 8'd10, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 8'd20,  1'b1, 1'b1, 19'd141, 8'd20, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b1, 8'd30,  1'b1, 1'b1, 19'd142, 8'd30, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 8'd40,  1'b1, 1'b1, 19'd143, 8'd40, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b1, 8'd100, 1'b0, 1'b0, 19'd143, 8'd40, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 19'd143, 8'd40, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b1, 8'd55,  1'b0, 1'b0, 19'd143, 8'd40, 1'b1, 1'b0, 1'b0};

    power_ON = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    step();
    step();
    chk("reset_outputs", 64'(outs()), 64'd0);
    power_ON = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd7;
    step();
    step();
    chk("idle_hold", 64'(outs()), 64'd0);
    in_valid = 1'b0;

    // clean back-to-back load, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      load_req = vt[i].req;
      in_valid = vt[i].vld;
      in_data  = vt[i].din;
      step();
      e = {vt[i].rdy, vt[i].we, vt[i].addr, vt[i].dat, vt[i].done, vt[i].err, vt[i].ps};
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(e));
    end
    load_req = 1'b0;
    in_valid = 1'b0;
    chk("good_pulses", 64'(psn), 64'd1);

    // bad checksum
    s = wn; p0 = psn;
    pulse_req();
    send_img(8'd10, 8'd20, 8'd30, 8'd40, 8'd99, 1'b0);
    step();
    chk("bad_err", 64'(load_err), 64'd1);
    chk("bad_done", 64'(load_done), 64'd0);
    chk("bad_pulses", 64'(psn - p0), 64'd0);
    chk_img("bad", s, 8'd10, 8'd20, 8'd30, 8'd40);

    // in_valid toggling every cycle
    s = wn; p0 = psn;
    pulse_req();
    chk("err_cleared", 64'({load_err, load_done, in_ready}), 64'b001);
    send_img(8'd10, 8'd20, 8'd30, 8'd40, 8'd100, 1'b1);
    step();
    chk("gap_done", 64'({load_done, load_err}), 64'b10);
    chk("gap_pulses", 64'(psn - p0), 64'd1);
    chk_img("gap", s, 8'd10, 8'd20, 8'd30, 8'd40);

    // reset after two accepted bytes, with the second write still on the port
    s = wn;
    pulse_req();
    send_byte(8'd10, 1'b0);
    send_byte(8'd20, 1'b0);
    chk("pre_rst_wr", 64'({dRamWrEn, dRamWrAddr}), 64'({1'b1, 19'd141}));
    power_ON = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd30;
    step();
    chk("rst_outputs", 64'(outs()), 64'd0);
    step();
    power_ON = 1'b1;
    step();
    step();
    step();
    chk("rst_idle", 64'({in_ready, dRamWrEn, load_done, load_err}), 64'd0);
    in_valid = 1'b0;
    chk("rst_nwr", 64'(wn - s), 64'd2);
    chk("rst_last_addr", 64'(wa[wn-1]), 64'd141);

    // load_req ignored during LOAD, honoured in DONE
    s = wn;
    pulse_req();
    send_byte(8'd10, 1'b0);
    pulse_req();
    chk("req_in_load", 64'({in_ready, load_done}), 64'b10);
    send_byte(8'd20, 1'b0);
    send_byte(8'd30, 1'b0);
    send_byte(8'd40, 1'b0);
    send_byte(8'd100, 1'b0);
    chk("reload_done1", 64'(load_done), 64'd1);
    chk_img("reload1", s, 8'd10, 8'd20, 8'd30, 8'd40);
    pulse_req();
    chk("reload_clear", 64'({load_done, load_err, in_ready}), 64'b001);
    s2 = wn;
    send_img(8'd5, 8'd6, 8'd7, 8'd8, 8'd26, 1'b0);
    step();
    chk("reload_done2", 64'(load_done), 64'd1);
    chk_img("reload2", s2, 8'd5, 8'd6, 8'd7, 8'd8);

    // address wrap at the top of the 19-bit space
    x0 = xn; s = wn;
    pulse_req();
    send_img(8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 1'b0);
    step();
    chk("wrap_done", 64'({w_done, w_err}), 64'b10);
    chk("wrap_nwr", 64'(xn - x0), 64'd4);
    chk("wrap_a0", 64'({xa[x0],   xd[x0]}),   64'({19'd524286, 8'd1}));
    chk("wrap_a1", 64'({xa[x0+1], xd[x0+1]}), 64'({19'd524287, 8'd2}));
    chk("wrap_a2", 64'({xa[x0+2], xd[x0+2]}), 64'({19'd0, 8'd3}));
    chk("wrap_a3", 64'({xa[x0+3], xd[x0+3]}), 64'({19'd1, 8'd4}));
    chk("wrap_main_done", 64'(load_done), 64'd1);
    chk_img("wrap_main", s, 8'd1, 8'd2, 8'd3, 8'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dram_loader.md
DRAM_LOADER -- requirements
Module: dram_loader

Interface
REQ-001 Parameter ADDR_W, default 19, data-RAM address width.
REQ-002 Parameter IMG_BYTES, default 65536, pixel bytes per image load; legal range 1..2^ADDR_W.
REQ-003 Parameter BASE_ADDR, default 0, first data-RAM address written.
REQ-004 Port clk  input  1  system clock, all logic on rising edge.
REQ-005 Port power_ON  input  1  reset, synchronous, active-low (0 = held in reset).
REQ-006 Port load_req  input  1  one-cycle request to begin a new image load.
REQ-007 Port in_valid  input  1  source byte valid.
REQ-008 Port in_data  input  8  source byte (pixels, then one checksum byte).
REQ-009 Port in_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port dRamWrEn  output  1  data-RAM write strobe.
REQ-011 Port dRamWrAddr  output  ADDR_W  data-RAM write address.
REQ-012 Port dRamWrData  output  8  data-RAM write data.
REQ-013 Port load_done  output  1  image loaded, checksum good (level).
REQ-014 Port load_err  output  1  checksum mismatch (level).
REQ-015 Port proc_start  output  1  one-cycle pulse to start the downsampling processor.

Function
REQ-016 The loader SHALL implement states IDLE, LOAD, CHECK, DONE, ERR.
REQ-017 A byte SHALL transfer only on a cycle with in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 exactly in LOAD and CHECK and 0 in all other states, with no combinational path from in_valid.
REQ-019 IDLE SHALL go to LOAD on load_req=1; the counter and the 8-bit checksum accumulator SHALL clear on that transition.
REQ-020 In LOAD, each transfer SHALL write the byte at BASE_ADDR + count, taken modulo 2^ADDR_W, then increment count.
REQ-021 Write latency SHALL be 1 cycle: on the next cycle, dRamWrEn=1 with the registered address and data; otherwise dRamWrEn=0.
REQ-022 dRamWrAddr and dRamWrData SHALL hold their last values while dRamWrEn=0.
REQ-023 The checksum SHALL be the sum of all pixel bytes modulo 256.
REQ-024 The transfer of pixel byte IMG_BYTES-1 SHALL move LOAD to CHECK; count SHALL NOT exceed IMG_BYTES-1.
REQ-025 In CHECK, the single transferred byte SHALL NOT be written to RAM and SHALL be compared with the accumulated checksum.
REQ-026 On a checksum match, CHECK SHALL go to DONE, set load_done=1 and pulse proc_start for exactly the first cycle in DONE.
REQ-027 On a checksum mismatch, CHECK SHALL go to ERR with load_err=1 and proc_start=0.
REQ-028 load_req SHALL be ignored in LOAD and CHECK.
REQ-029 load_req in DONE or ERR SHALL clear load_done and load_err, clear the counter and checksum, and enter LOAD on the next cycle.
REQ-030 Gaps in in_valid SHALL stall the loader indefinitely without state change or writes.
REQ-031 The final pixel write (dRamWrEn) SHALL occur on the cycle the state is CHECK, before any DONE entry.

Reset
REQ-032 power_ON=0 at a clock edge SHALL force IDLE, count=0, checksum=0, in_ready=0, dRamWrEn=0, dRamWrAddr=0, dRamWrData=0, load_done=0, load_err=0, proc_start=0.
REQ-033 Reset asserted mid-LOAD SHALL abort the load, and no further write SHALL occur, including a write pending from the previous cycle.
REQ-034 After reset releases, the loader SHALL stay in IDLE until load_req.

Verification (IMG_BYTES=4, BASE_ADDR=140)
REQ-035 Bench: load_req, bytes 10,20,30,40 then 100, all back-to-back -> writes at 140..143 with 10,20,30,40 one cycle after each accept, load_done=1, proc_start high for exactly 1 cycle.
REQ-036 Bench: same pixels, checksum byte 99 -> load_err=1, load_done=0, no proc_start, exactly 4 writes.
REQ-037 Bench: in_valid toggling 1/0 every cycle -> identical RAM contents and result as REQ-035, no write on idle cycles.
REQ-038 Bench: power_ON=0 after 2 accepted bytes -> all outputs 0 next cycle, no write to 142, IDLE held until load_req.
REQ-039 Bench: load_req pulsed during LOAD, then again in DONE -> first ignored; second clears load_done and reloads from address 140.
REQ-040 Bench: BASE_ADDR=2^19-2, pixels 1,2,3,4, checksum 10 -> writes to 524286, 524287, 0, 1 and load_done=1.
